// File: rtl/wiphy_pkg.sv
// Shared types, constants and table helpers for the WiPHY transmit path.
package wiphy_pkg;

    localparam int STF_LEN    = 160;
    localparam int LTF_LEN    = 160;
    localparam int LTF_CP     = 32;
    localparam int SYM_LEN    = 64;
    localparam int STF_PERIOD = 16;
    localparam int IDX_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        STF,
        LTF,
        PAYLOAD,
        GAP
    } state_t;

    typedef enum logic {
        SEL_STF = 1'b0,
        SEL_LTF = 1'b1
    } rom_sel_t;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } sample_t;

    // Tables are written in thousandths; convert to Q1.15, rounding half away from zero.
    function automatic logic signed [15:0] q15(input int milli);
        int mag;
        mag = (((milli < 0) ? -milli : milli) * 32768 + 500) / 1000;
        return (milli < 0) ? 16'(-mag) : 16'(mag);
    endfunction

    function automatic sample_t cplx(input int mi, input int mq);
        sample_t s;
        s.i = q15(mi);
        s.q = q15(mq);
        return s;
    endfunction

endpackage

// File: rtl/preamble_rom.sv
// Combinational 802.11 short/long training symbol tables, looked up by (sel, index).
module preamble_rom
    import wiphy_pkg::*;
(
    input  rom_sel_t   sel,
    input  logic [5:0] index,
    output sample_t    sample
);

    sample_t    stf;
    sample_t    ltf_base;
    logic [5:0] ltf_k;
    logic       mirror;

    always_comb begin
        case (index[3:0])
            4'd0:    stf = cplx(  46,   46);
            4'd1:    stf = cplx(-132,    2);
            4'd2:    stf = cplx( -13,  -79);
            4'd3:    stf = cplx( 143,  -13);
            4'd4:    stf = cplx(  92,    0);
            4'd5:    stf = cplx( 143,  -13);
            4'd6:    stf = cplx( -13,  -79);
            4'd7:    stf = cplx(-132,    2);
            4'd8:    stf = cplx(  46,   46);
            4'd9:    stf = cplx(   2, -132);
            4'd10:   stf = cplx( -79,  -13);
            4'd11:   stf = cplx( -13,  143);
            4'd12:   stf = cplx(   0,   92);
            4'd13:   stf = cplx( -13,  143);
            4'd14:   stf = cplx( -79,  -13);
            4'd15:   stf = cplx(   2, -132);
            default: stf = '0;
        endcase
    end

    // The long symbol has a real spectrum, so x[64-k] = conj(x[k]); only 0..32 are stored.
    always_comb begin
        mirror = (index > 6'd32);
        ltf_k  = mirror ? 6'(7'd64 - {1'b0, index}) : index;
    end

    always_comb begin
        case (ltf_k)
            6'd0:    ltf_base = cplx( 156,    0);
            6'd1:    ltf_base = cplx(  -5, -120);
            6'd2:    ltf_base = cplx(  40, -111);
            6'd3:    ltf_base = cplx(  97,   83);
            6'd4:    ltf_base = cplx(  21,   28);
            6'd5:    ltf_base = cplx(  60,  -88);
            6'd6:    ltf_base = cplx(-115,  -55);
            6'd7:    ltf_base = cplx( -38, -106);
            6'd8:    ltf_base = cplx(  98,  -26);
            6'd9:    ltf_base = cplx(  53,    4);
            6'd10:   ltf_base = cplx(   1, -115);
            6'd11:   ltf_base = cplx(-137,  -47);
            6'd12:   ltf_base = cplx(  24,  -59);
            6'd13:   ltf_base = cplx(  59,  -15);
            6'd14:   ltf_base = cplx( -22,  161);
            6'd15:   ltf_base = cplx( 119,   -4);
            6'd16:   ltf_base = cplx(  62,  -62);
            6'd17:   ltf_base = cplx(  37,   98);
            6'd18:   ltf_base = cplx( -57,   39);
            6'd19:   ltf_base = cplx(-131,   65);
            6'd20:   ltf_base = cplx(  82,   92);
            6'd21:   ltf_base = cplx(  70,   14);
            6'd22:   ltf_base = cplx( -60,   81);
            6'd23:   ltf_base = cplx( -56,  -22);
            6'd24:   ltf_base = cplx( -35, -151);
            6'd25:   ltf_base = cplx(-122,  -17);
            6'd26:   ltf_base = cplx(-127,  -21);
            6'd27:   ltf_base = cplx(  75,  -74);
            6'd28:   ltf_base = cplx(  -3,   54);
            6'd29:   ltf_base = cplx( -92,  115);
            6'd30:   ltf_base = cplx(  92,  106);
            6'd31:   ltf_base = cplx(  12,   98);
            6'd32:   ltf_base = cplx(-156,    0);
            default: ltf_base = '0;
        endcase
    end

    always_comb begin
        sample = stf;
        if (sel == SEL_LTF) begin
            sample.i = ltf_base.i;
            sample.q = mirror ? -ltf_base.q : ltf_base.q;
        end
    end

endmodule

// File: rtl/tx_framer.sv
// Frame transmitter: STF + LTF preamble, payload stream, zero gap; every step is paced by DAC strobes.
// Optional WIPHY_TX_UNDERFLOW_HOLD_EN: a starved payload strobe repeats the last payload sample.
module tx_framer
    import wiphy_pkg::*;
#(
    parameter int GAP_LEN     = 16,
    parameter int SCALE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        dac_valid,
    output logic [31:0] dac_data,
    output logic        busy,
    output logic        done,
    output logic        underflow
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [31:0]      data_next;
    logic             done_next;
    logic             underflow_next;
    rom_sel_t         rom_sel;
    logic [5:0]       rom_index;
    sample_t          rom_sample;
    sample_t          scaled;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
    logic [31:0]      hold, hold_next;
`endif

    preamble_rom u_rom (
        .sel    (rom_sel),
        .index  (rom_index),
        .sample (rom_sample)
    );

    // LTF walks 32..63 as cyclic prefix, then 0..63 twice; IDLE addresses STF sample 0.
    always_comb begin
        rom_sel   = (state == LTF) ? SEL_LTF : SEL_STF;
        rom_index = '0;
        if (state == STF)
            rom_index = 6'(idx % IDX_W'(STF_PERIOD));
        else if (state == LTF)
            rom_index = (idx < IDX_W'(LTF_CP)) ? 6'(idx + IDX_W'(SYM_LEN - LTF_CP))
                                               : 6'(idx - IDX_W'(LTF_CP));
    end

    always_comb begin
        scaled.i = $signed(rom_sample.i) >>> SCALE_SHIFT;
        scaled.q = $signed(rom_sample.q) >>> SCALE_SHIFT;
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        data_next      = dac_data;
        done_next      = 1'b0;
        underflow_next = 1'b0;
        s_ready        = 1'b0;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
        hold_next      = hold;
`endif
        case (state)
            IDLE: begin
                if (dac_valid) begin
                    if (s_valid) begin
                        state_next = STF;
                        idx_next   = IDX_W'(1);
                        data_next  = scaled;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
                        hold_next  = '0;
`endif
                    end else begin
                        data_next = '0;
                    end
                end
            end
            STF: begin
                if (dac_valid) begin
                    data_next = scaled;
                    if (idx == IDX_W'(STF_LEN - 1)) begin
                        state_next = LTF;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            LTF: begin
                if (dac_valid) begin
                    data_next = scaled;
                    if (idx == IDX_W'(LTF_LEN - 1)) begin
                        state_next = PAYLOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                s_ready = dac_valid;
                if (dac_valid) begin
                    if (s_valid) begin
                        data_next = s_data;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
                        hold_next = s_data;
`endif
                        if (s_last) begin
                            if (GAP_LEN == 0) begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end else begin
                                state_next = GAP;
                                idx_next   = '0;
                            end
                        end
                    end else begin
                        underflow_next = 1'b1;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
                        data_next = hold;
`else
                        data_next = '0;
`endif
                    end
                end
            end
            GAP: begin
                if (dac_valid) begin
                    data_next = '0;
                    if (idx == IDX_W'(GAP_LEN - 1)) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            dac_data  <= '0;
            done      <= 1'b0;
            underflow <= 1'b0;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
            hold      <= '0;
`endif
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            dac_data  <= data_next;
            done      <= done_next;
            underflow <= underflow_next;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
            hold      <= hold_next;
`endif
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: a default instance and a GAP_LEN=0 / SCALE_SHIFT=2 instance,
// checked cycle by cycle against a frame-sequence model; honours WIPHY_TX_UNDERFLOW_HOLD_EN.
module tb_tx_framer;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        dv  [2];
    logic        sv  [2];
    logic        sl  [2];
    logic [31:0] sd  [2];
    logic        rdy [2];
    logic [31:0] dd  [2];
    logic        bsy [2];
    logic        dn  [2];
    logic        uf  [2];

    int          checks = 0;
    int          errors = 0;
    int          gap_len [2] = '{16, 0};
    int          shift   [2] = '{0, 2};
    logic [31:0] exp_out [2] = '{32'h0, 32'h0};

    int stf_i [16] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
    int stf_q [16] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
    int ltf_i [64] = '{156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
                       62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
                       -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
                       62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
    int ltf_q [64] = '{0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
                       -62, 98, 39, 65, 92, 14, 81, -22, -151, -17, -21, -74, 54, 115, 106, 98,
                       0, -98, -106, -115, -54, 74, 21, 17, 151, 22, -81, -14, -92, -65, -39, -98,
                       62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};

    always #5 clk = ~clk;

    tx_framer dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (sv[0]),
        .s_ready   (rdy[0]),
        .s_data    (sd[0]),
        .s_last    (sl[0]),
        .dac_valid (dv[0]),
        .dac_data  (dd[0]),
        .busy      (bsy[0]),
        .done      (dn[0]),
        .underflow (uf[0])
    );

    tx_framer #(.GAP_LEN(0), .SCALE_SHIFT(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (sv[1]),
        .s_ready   (rdy[1]),
        .s_data    (sd[1]),
        .s_last    (sl[1]),
        .dac_valid (dv[1]),
        .dac_data  (dd[1]),
        .busy      (bsy[1]),
        .done      (dn[1]),
        .underflow (uf[1])
    );

    function automatic int to_q15(input int milli);
        real r;
        r = milli * 32.768;
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    function automatic logic [31:0] pack_iq(input int mi, input int mq, input int sh);
        int vi, vq;
        vi = to_q15(mi) >>> sh;
        vq = to_q15(mq) >>> sh;
        return {vq[15:0], vi[15:0]};
    endfunction

    // Sample number pos of the 320-sample preamble: STF repeats every 16, LTF is ((j + 32) mod 64).
    function automatic logic [31:0] preamble(input int pos, input int sh);
        int k;
        if (pos < 160)
            return pack_iq(stf_i[pos % 16], stf_q[pos % 16], sh);
        k = (pos - 160 + 32) % 64;
        return pack_iq(ltf_i[k], ltf_q[k], sh);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One frame on instance d. mode: 0 strobe every cycle, 1 alternate, 2 random.
    task automatic apply_stimulus(input int d, input int beats, input int mode, input bit counting,
                                  input int starve_at, input int starve_n, input int abort_at);
        logic [31:0] payload [$];
        logic [31:0] hold;
        int          phase, pos, beat, starved, gap_left, strobes, dones;
        bit          strobe, starving, exp_done, exp_uf, finished;
        for (int b = 0; b < beats; b++)
            payload.push_back(counting ? 32'h0001_0001 * 32'(b + 1) : $urandom);
        hold     = '0;
        phase    = 0;
        pos      = 0;
        beat     = 0;
        starved  = 0;
        gap_left = 0;
        strobes  = 0;
        dones    = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            strobe   = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            starving = (phase == 2) && (beat == starve_at) && (starved < starve_n);
            dv[d] = strobe;
            if (phase == 3) begin
                sv[d] = 1'($urandom_range(0, 1));
                sd[d] = $urandom;
                sl[d] = 1'($urandom_range(0, 1));
            end else begin
                sv[d] = !starving;
                sd[d] = payload[(phase == 2) ? beat : 0];
                sl[d] = (phase == 2) ? (beat == beats - 1) : (beats == 1);
            end
            #1;
            check_output("s_ready", 32'(rdy[d]), (phase == 2) ? 32'(strobe) : 32'h0);
            @(posedge clk);
            #1;
            exp_done = 1'b0;
            exp_uf   = 1'b0;
            if (strobe) begin
                strobes++;
                case (phase)
                    0: begin
                        exp_out[d] = preamble(0, shift[d]);
                        pos   = 1;
                        phase = 1;
                    end
                    1: begin
                        exp_out[d] = preamble(pos, shift[d]);
                        pos++;
                        if (pos == 320) phase = 2;
                    end
                    2: begin
                        if (starving) begin
                            exp_uf = 1'b1;
                            starved++;
`ifdef WIPHY_TX_UNDERFLOW_HOLD_EN
                            exp_out[d] = hold;
`else
                            exp_out[d] = '0;
`endif
                        end else begin
                            exp_out[d] = payload[beat];
                            hold = payload[beat];
                            beat++;
                            if (beat == beats) begin
                                if (gap_len[d] == 0) begin
                                    phase    = 4;
                                    exp_done = 1'b1;
                                end else begin
                                    phase    = 3;
                                    gap_left = gap_len[d];
                                end
                            end
                        end
                    end
                    3: begin
                        exp_out[d] = '0;
                        gap_left--;
                        if (gap_left == 0) begin
                            phase    = 4;
                            exp_done = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (dn[d]) dones++;
            check_output("dac_data", dd[d], exp_out[d]);
            check_output("busy", 32'(bsy[d]), 32'(phase >= 1 && phase <= 3));
            check_output("done", 32'(dn[d]), 32'(exp_done));
            check_output("underflow", 32'(uf[d]), 32'(exp_uf));
            if (phase == 4 || (abort_at >= 0 && strobes == abort_at)) finished = 1'b1;
        end
        dv[d] = 1'b0;
        sv[d] = 1'b0;
        sl[d] = 1'b0;
        check_output("frame_reached_end", 32'(finished), 32'h1);
        check_output("done_count", 32'(dones), (abort_at >= 0) ? 32'h0 : 32'h1);
    endtask

    task automatic idle_strobes(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            dv[d] = 1'b1;
            sv[d] = 1'b0;
            sd[d] = $urandom;
            sl[d] = 1'b0;
            #1;
            check_output("idle_s_ready", 32'(rdy[d]), 32'h0);
            @(posedge clk);
            #1;
            exp_out[d] = '0;
            check_output("idle_dac_data", dd[d], exp_out[d]);
            check_output("idle_busy", 32'(bsy[d]), 32'h0);
        end
        dv[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            dv[d] = 1'b1;
            sv[d] = 1'b1;
            sd[d] = 32'hDEAD_BEEF;
            sl[d] = 1'b0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check_output("reset_dac_data", dd[d], 32'h0);
            check_output("reset_busy", 32'(bsy[d]), 32'h0);
            check_output("reset_done", 32'(dn[d]), 32'h0);
            check_output("reset_underflow", 32'(uf[d]), 32'h0);
            check_output("reset_s_ready", 32'(rdy[d]), 32'h0);
        end
        @(posedge clk);
        #1;
        check_output("reset_holds_idle", 32'(bsy[0]), 32'h0);
        for (int d = 0; d < 2; d++) begin
            dv[d] = 1'b0;
            sv[d] = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] 4-beat counting frame, strobe every cycle");
        apply_stimulus(0, 4, 0, 1'b1, -1, 0, -1);
        idle_strobes(0, 3);

        $display("[TB] same frame, strobe toggling");
        apply_stimulus(0, 4, 1, 1'b1, -1, 0, -1);

        $display("[TB] random strobes, starved for 3 strobes mid-payload");
        apply_stimulus(0, 8, 2, 1'b0, 3, 3, -1);

        $display("[TB] reset at LTF index 50, then a fresh frame");
        apply_stimulus(0, 4, 0, 1'b1, -1, 0, 210);
        dv[0] = 1'b1;
        sv[0] = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        exp_out[0] = '0;
        check_output("midreset_dac_data", dd[0], exp_out[0]);
        check_output("midreset_busy", 32'(bsy[0]), 32'h0);
        check_output("midreset_s_ready", 32'(rdy[0]), 32'h0);
        check_output("midreset_done", 32'(dn[0]), 32'h0);
        dv[0] = 1'b0;
        sv[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(0, 5, 2, 1'b0, 0, 2, -1);

        $display("[TB] GAP_LEN=0, SCALE_SHIFT=2: back-to-back single-beat frames");
        apply_stimulus(1, 1, 0, 1'b0, -1, 0, -1);
        apply_stimulus(1, 1, 0, 1'b0, -1, 0, -1);
        apply_stimulus(1, 6, 2, 1'b0, 4, 3, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
